// File: rtl/reg_mask_sequencer_pkg.sv
// reg_pkg: shared sizing and FSM state encoding for the register-mask sequencer.
//   NREGS : number of GPRs, width of the select mask
//   IDX_W : register index width (clog2(NREGS))
//   state_t : IDLE / RUN / DONE
package reg_pkg;
  localparam int NREGS = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/reg_mask_sequencer_if.sv
// reg_mask_sequencer_if: start/mask request side and indexed-transfer
// handshake of the register-mask sequencer.
//   start, mask, ready           : master -> sequencer
//   valid, bin, r_sig, busy,
//   done, count                  : sequencer -> master
interface reg_mask_sequencer_if;
  import reg_pkg::*;

  logic             start;
  logic [NREGS-1:0] mask;
  logic             ready;
  logic             valid;
  logic [IDX_W-1:0] bin;
  logic [NREGS-1:0] r_sig;
  logic             busy;
  logic             done;
  logic [IDX_W:0]   count;

  modport master (
    output start, mask, ready,
    input  valid, bin, r_sig, busy, done, count
  );

  modport slave (
    input  start, mask, ready,
    output valid, bin, r_sig, busy, done, count
  );
endinterface

// File: rtl/reg_mask_sequencer_sig_to_binary.sv
// reg_sig_to_binary: combinational priority encoder, NREGS-bit select vector
// to IDX_W-bit index of the winning set bit.
//   i_sig : select vector
//   o_bin : index of the winning bit (0 when i_sig is empty)
//   o_any : i_sig has at least one bit set
// Macro REG_MASK_DESCEND_EN: highest set bit wins; otherwise lowest set bit wins.
module reg_sig_to_binary
  import reg_pkg::*;
(
  input  logic [NREGS-1:0] i_sig,
  output logic [IDX_W-1:0] o_bin,
  output logic             o_any
);

  // Last assignment in loop order wins, so the loop runs from the
  // lowest-priority end toward the highest-priority end.
  always_comb begin
    o_bin = '0;
`ifdef REG_MASK_DESCEND_EN
    for (int i = 0; i < NREGS; i++)
      if (i_sig[i]) o_bin = IDX_W'(i);
`else
    for (int i = NREGS - 1; i >= 0; i--)
      if (i_sig[i]) o_bin = IDX_W'(i);
`endif
  end

  assign o_any = |i_sig;

endmodule

// File: rtl/reg_mask_sequencer.sv
// reg_mask_sequencer: walks a captured register-select mask and issues one
// register index per accepted (valid && ready) transfer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_mask_sequencer_if.slave (start/mask/ready in;
//                valid/bin/r_sig/busy/done/count out)
// Macro REG_MASK_DESCEND_EN (inside reg_sig_to_binary): scan r7 down to r0
// instead of r0 up to r7.
module reg_mask_sequencer
  import reg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  reg_mask_sequencer_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREGS-1:0] r_pending;
  logic [IDX_W:0]   r_count;

  logic [IDX_W-1:0] w_bin;
  logic             w_any;
  logic [NREGS-1:0] w_onehot;
  logic [NREGS-1:0] w_pending_nxt;
  logic             w_valid;
  logic             w_xfer;

  reg_sig_to_binary u_enc (
    .i_sig (r_pending),
    .o_bin (w_bin),
    .o_any (w_any)
  );

  assign w_onehot      = NREGS'(1) << w_bin;
  assign w_pending_nxt = r_pending & ~w_onehot;
  assign w_valid       = (r_state == RUN) && w_any;
  assign w_xfer        = w_valid && bus.ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = (bus.mask != '0) ? RUN : DONE;
      RUN:  if (w_xfer && (w_pending_nxt == '0)) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && bus.start) begin
        r_pending <= bus.mask;
        r_count   <= '0;
      end else if (w_xfer) begin
        r_pending <= w_pending_nxt;
        r_count   <= r_count + (IDX_W+1)'(1);
      end
    end
  end

  // Index and one-hot are forced to zero whenever no transfer is offered.
  assign bus.valid = w_valid;
  assign bus.bin   = w_valid ? w_bin : '0;
  assign bus.r_sig = w_valid ? w_onehot : '0;
  assign bus.busy  = (r_state == RUN) || (r_state == DONE);
  assign bus.done  = (r_state == DONE);
  assign bus.count = r_count;

endmodule
